dpll_loop_filter: RTL and testbench

//   Digital PI loop filter for the DPLL. Consumes signed phase-error samples from the phase detector.

---
 rtl/dpll_loop_filter.sv | 174 +++++++++++++++++
 tb/tb_dpll_loop_filter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpll_loop_filter.sv
// PI loop filter for the DPLL: signed phase error in, saturated unsigned VCO control word out.
// Two-stage pipeline with an ACQUIRE/TRACK lock detector that selects boosted or nominal gains.
module dpll_loop_filter #(
    parameter int unsigned CTRL_W              = 20,
    parameter int unsigned ERR_W               = 12,
    parameter logic [CTRL_W-1:0] CTRL_INIT     = 20'h80000,
    parameter int unsigned KP                  = 64,
    parameter int unsigned KI                  = 4,
    parameter int unsigned FRAC                = 4,
    parameter int unsigned ACQ_SHIFT           = 2,
    parameter int unsigned LOCK_TOL            = 8,
    parameter int unsigned LOCK_CNT            = 16,
    parameter int unsigned UNLOCK_CNT          = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ERR_W-1:0] phase_err,
    input  logic                    err_valid,
    input  logic                    freeze,
    input  logic                    clear,
    output logic [CTRL_W-1:0]       dig_ctrl_voltage,
    output logic                    ctrl_valid,
    output logic                    locked
);

    localparam int unsigned SUM_W = CTRL_W + ERR_W + 8;
    localparam int unsigned CNT_W = $clog2(LOCK_CNT + UNLOCK_CNT + 1);

    localparam logic signed [SUM_W-1:0] INIT_S    = $signed({{(SUM_W-CTRL_W){1'b0}}, CTRL_INIT});
    localparam logic signed [SUM_W-1:0] MAX_S     = $signed({{(SUM_W-CTRL_W){1'b0}}, {CTRL_W{1'b1}}});
    localparam logic signed [SUM_W-1:0] INTEG_MIN = -INIT_S;
    localparam logic signed [SUM_W-1:0] INTEG_MAX = MAX_S - INIT_S;
    localparam logic signed [SUM_W-1:0] KP_S      = SUM_W'(KP);
    localparam logic signed [SUM_W-1:0] KI_S      = SUM_W'(KI);
    localparam logic signed [SUM_W-1:0] TOL_S     = SUM_W'(LOCK_TOL);
    localparam logic [CNT_W-1:0]        LOCK_C    = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]        UNLOCK_C  = CNT_W'(UNLOCK_CNT);

    typedef enum logic {
        ACQUIRE,
        TRACK
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next, cnt_inc;
    logic                    accept;
    logic signed [SUM_W-1:0] err_s, err_abs;
    logic signed [SUM_W-1:0] p_raw, i_raw, p_term, i_term;
    logic signed [SUM_W-1:0] integ, integ_sum, integ_next, p_reg;
    logic signed [SUM_W-1:0] ctrl_sum;
    logic                    in_tol;
    logic                    s1_valid, s1_clr, clear_d;

    assign accept  = err_valid & ~freeze & ~clear;
    assign err_s   = $signed({{(SUM_W-ERR_W){phase_err[ERR_W-1]}}, phase_err});
    assign err_abs = err_s[SUM_W-1] ? -err_s : err_s;
    assign in_tol  = (err_abs <= TOL_S);
    assign cnt_inc = cnt + 1'b1;

    // Gain mode follows the state before this sample's lock update.
    always_comb begin
        p_raw  = (err_s * KP_S) >>> FRAC;
        i_raw  = (err_s * KI_S) >>> FRAC;
        p_term = p_raw;
        i_term = i_raw;
        if (state == ACQUIRE) begin
            p_term = p_raw <<< ACQ_SHIFT;
            i_term = i_raw <<< ACQ_SHIFT;
        end
        integ_sum  = integ + i_term;
        integ_next = integ_sum;
        if (integ_sum < INTEG_MIN) begin
            integ_next = INTEG_MIN;
        end else if (integ_sum > INTEG_MAX) begin
            integ_next = INTEG_MAX;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (clear) begin
            state_next = ACQUIRE;
            cnt_next   = '0;
        end else if (accept) begin
            case (state)
                ACQUIRE: begin
                    if (!in_tol) begin
                        cnt_next = '0;
                    end else if (cnt_inc == LOCK_C) begin
                        state_next = TRACK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                TRACK: begin
                    if (in_tol) begin
                        cnt_next = '0;
                    end else if (cnt_inc == UNLOCK_C) begin
                        state_next = ACQUIRE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                    state_next = ACQUIRE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACQUIRE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign locked = (state == TRACK);

    // Stage 1: integrator update and proportional term capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ    <= '0;
            p_reg    <= '0;
            s1_valid <= 1'b0;
            s1_clr   <= 1'b0;
            clear_d  <= 1'b0;
        end else begin
            clear_d  <= clear;
            s1_clr   <= clear & ~clear_d;
            s1_valid <= accept;
            if (clear) begin
                integ <= '0;
                p_reg <= '0;
            end else if (accept) begin
                integ <= integ_next;
                p_reg <= p_term;
            end
        end
    end

    assign ctrl_sum = INIT_S + p_reg + integ;

    // Stage 2: output saturation; a clear edge discards the sample still in stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_ctrl_voltage <= CTRL_INIT;
            ctrl_valid       <= 1'b0;
        end else begin
            ctrl_valid <= 1'b0;
            if (s1_clr) begin
                dig_ctrl_voltage <= CTRL_INIT;
                ctrl_valid       <= 1'b1;
            end else if (s1_valid && !clear) begin
                ctrl_valid <= 1'b1;
                if (ctrl_sum < 0) begin
                    dig_ctrl_voltage <= '0;
                end else if (ctrl_sum > MAX_S) begin
                    dig_ctrl_voltage <= '1;
                end else begin
                    dig_ctrl_voltage <= ctrl_sum[CTRL_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_dpll_loop_filter.sv
// Self-checking bench for dpll_loop_filter: a behavioural model pushes expected control
// words into a queue as samples are driven; a negedge monitor pops and compares on ctrl_valid.
module tb_dpll_loop_filter;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [11:0] phase_err = '0;
    logic               err_valid = 1'b0;
    logic               freeze = 1'b0;
    logic               clear = 1'b0;
    logic [19:0]        dig_ctrl_voltage;
    logic               ctrl_valid;
    logic               locked;

    int compared   = 0;
    int mismatched = 0;
    int valid_count = 0;

    longint exp_q[$];

    longint integ_m;
    bit     track_m;
    int     cnt_m;

    dpll_loop_filter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .phase_err        (phase_err),
        .err_valid        (err_valid),
        .freeze           (freeze),
        .clear            (clear),
        .dig_ctrl_voltage (dig_ctrl_voltage),
        .ctrl_valid       (ctrl_valid),
        .locked           (locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && ctrl_valid) begin
            longint e;
            valid_count++;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_ctrl_valid: dig=%0d, no result expected", dig_ctrl_voltage);
            end else begin
                e = exp_q.pop_front();
                if (longint'(dig_ctrl_voltage) !== e) begin
                    mismatched++;
                    $display("FAIL scoreboard_dig: got %0d expected %0d", dig_ctrl_voltage, e);
                end
            end
        end
    end

    function automatic void model_reset();
        integ_m = 0;
        track_m = 0;
        cnt_m   = 0;
    endfunction

    // Reference PI filter with defaults: KP=64 KI=4 FRAC=4 boost x4, integ in [-524288, 524287].
    function automatic longint model_sample(int err);
        longint p, i, sum;
        int     mag;
        p = (longint'(err) * 64) >>> 4;
        i = (longint'(err) * 4) >>> 4;
        if (!track_m) begin
            p = p * 4;
            i = i * 4;
        end
        integ_m = integ_m + i;
        if (integ_m < -524288) integ_m = -524288;
        if (integ_m > 524287)  integ_m = 524287;
        sum = 524288 + p + integ_m;
        if (sum < 0)       sum = 0;
        if (sum > 1048575) sum = 1048575;
        mag = (err < 0) ? -err : err;
        if (!track_m) begin
            cnt_m = (mag <= 8) ? cnt_m + 1 : 0;
            if (cnt_m == 16) begin track_m = 1; cnt_m = 0; end
        end else begin
            cnt_m = (mag > 8) ? cnt_m + 1 : 0;
            if (cnt_m == 4) begin track_m = 0; cnt_m = 0; end
        end
        return sum;
    endfunction

    task automatic apply_reset();
        rst_n     = 1'b0;
        err_valid = 1'b0;
        freeze    = 1'b0;
        clear     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        model_reset();
    endtask

    task automatic send(input int err);
        exp_q.push_back(model_sample(err));
        phase_err = 12'(err);
        err_valid = 1'b1;
        @(posedge clk);
        #1 err_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        compared += 3;
        if (dig_ctrl_voltage !== 20'd524288) begin
            mismatched++; $display("FAIL reset_dig: got %0d expected 524288", dig_ctrl_voltage);
        end
        if (ctrl_valid !== 1'b0) begin
            mismatched++; $display("FAIL reset_valid: got %b expected 0", ctrl_valid);
        end
        if (locked !== 1'b0) begin
            mismatched++; $display("FAIL reset_locked: got %b expected 0", locked);
        end
        send(0);
        compared++;
        if (ctrl_valid !== 1'b0) begin
            mismatched++; $display("FAIL latency_early: got %b expected 0", ctrl_valid);
        end
        @(posedge clk); #1;
        compared += 2;
        if (ctrl_valid !== 1'b1) begin
            mismatched++; $display("FAIL latency_pulse: got %b expected 1", ctrl_valid);
        end
        if (locked !== 1'b0) begin
            mismatched++; $display("FAIL first_locked: got %b expected 0", locked);
        end
        drain();
    endtask

    task automatic test_acquire();
        apply_reset();
        send(16);
        send(16);
        drain();
        compared++;
        if (dig_ctrl_voltage !== 20'd524576) begin
            mismatched++; $display("FAIL acquire_dig: got %0d expected 524576", dig_ctrl_voltage);
        end
    endtask

    task automatic test_lock();
        apply_reset();
        for (int k = 0; k < 15; k++) send(0);
        compared++;
        if (locked !== 1'b0) begin
            mismatched++; $display("FAIL lock_early: got %b expected 0", locked);
        end
        send(0);
        compared++;
        if (locked !== 1'b1) begin
            mismatched++; $display("FAIL lock_rise: got %b expected 1", locked);
        end
        send(16);
        drain();
        compared++;
        if (dig_ctrl_voltage !== 20'd524356) begin
            mismatched++; $display("FAIL track_gain_dig: got %0d expected 524356", dig_ctrl_voltage);
        end
    endtask

    task automatic test_freeze_clear();
        logic [19:0] dig0;
        int          vc0;
        dig0 = dig_ctrl_voltage;
        vc0  = valid_count;
        freeze = 1'b1;
        for (int k = 0; k < 5; k++) begin
            phase_err = 12'sd2047;
            err_valid = 1'b1;
            @(posedge clk);
        end
        #1 err_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 freeze = 1'b0;
        compared += 3;
        if (dig_ctrl_voltage !== dig0) begin
            mismatched++; $display("FAIL freeze_dig: got %0d expected %0d", dig_ctrl_voltage, dig0);
        end
        if (locked !== 1'b1) begin
            mismatched++; $display("FAIL freeze_locked: got %b expected 1", locked);
        end
        if (valid_count !== vc0) begin
            mismatched++; $display("FAIL freeze_valid: got %0d pulses expected 0", valid_count - vc0);
        end
        send(0);
        drain();
        vc0 = valid_count;
        exp_q.push_back(524288);
        model_reset();
        clear = 1'b1;
        repeat (3) @(posedge clk);
        #1 clear = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1;
        compared += 3;
        if (locked !== 1'b0) begin
            mismatched++; $display("FAIL clear_locked: got %b expected 0", locked);
        end
        if (dig_ctrl_voltage !== 20'd524288) begin
            mismatched++; $display("FAIL clear_dig: got %0d expected 524288", dig_ctrl_voltage);
        end
        if (valid_count - vc0 !== 1) begin
            mismatched++; $display("FAIL clear_pulses: got %0d expected 1", valid_count - vc0);
        end
    endtask

    task automatic test_windup();
        apply_reset();
        for (int k = 0; k < 300; k++) send(2047);
        drain();
        compared++;
        if (dig_ctrl_voltage !== 20'd1048575) begin
            mismatched++; $display("FAIL windup_sat: got %0d expected 1048575", dig_ctrl_voltage);
        end
        send(-1);
        drain();
        compared++;
        if (dig_ctrl_voltage !== 20'd1048555) begin
            mismatched++; $display("FAIL windup_release: got %0d expected 1048555", dig_ctrl_voltage);
        end
    endtask

    task automatic test_reset_mid();
        int vc0;
        send(5);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        model_reset();
        #1;
        compared++;
        if (dig_ctrl_voltage !== 20'd524288) begin
            mismatched++; $display("FAIL midreset_dig: got %0d expected 524288", dig_ctrl_voltage);
        end
        vc0 = valid_count;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if (valid_count !== vc0) begin
            mismatched++; $display("FAIL midreset_valid: got %0d pulses expected 0", valid_count - vc0);
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_lock();
        test_freeze_clear();
        test_windup();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
